// File: rtl/serial_add_ctrl_if.sv
// Operand intake and result delivery bundle for the bit-serial adder controller.
// Carries both valid/ready handshakes plus the busy status.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: a single full adder sums two WIDTH-bit operands
// LSB first over WIDTH cycles, with valid/ready intake and result delivery.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             carry_q, carry_d;
  logic             out_cout_q, out_cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             fa_sum, fa_cout;

  // Bit counter increment built from gates so the full adder stays the only arithmetic.
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    logic c;
    inc = v;
    c   = 1'b1;
    for (int i = 0; i < int'(CW); i++) begin
      inc[i] = v[i] ^ c;
      c      = c & v[i];
    end
  endfunction

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d   = bus.in_a;
          b_sh_d   = bus.in_b;
          carry_d  = bus.in_cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_sum;
        carry_d             = fa_cout;
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        cnt_d               = inc(cnt_q);
        if (cnt_q == LAST) begin
          out_sum_d  = sum_sh_d;
          out_cout_d = fa_cout;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; handshake flags are decoded from next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: one internal `full_adder` instance (ports a, b, cin, sum, cout) adds two WIDTH-bit operands over WIDTH clock cycles, LSB first.
- Operand intake and result delivery use valid/ready handshakes.
- Area-cheap alternative to a ripple-carry array; used wherever add throughput is low and area matters.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands valid.
- in_ready  output  1  controller can accept operands; high only in IDLE.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  sum bits.
- out_cout  output  1  final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock, clk; reset synchronous and active-low, rst_n.
- States: IDLE, RUN, DONE.
- Reset: rst_n low at an edge forces the following, regardless of state; a reset mid-RUN or mid-DONE discards the operation.
  - State to IDLE.
  - Operand shift registers, carry register and bit counter to 0.
  - out_sum to 0, out_cout to 0.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0.
- Decoding: in_ready, out_valid and busy are decoded from state only, with no combinational path from inputs.
- IDLE:
  - Accept when in_valid && in_ready at an edge.
  - On accept: latch in_a and in_b into shift registers a_sh and b_sh, carry register to in_cin, counter to 0, sum shift register to 0, then go to RUN.
  - in_valid low: remain in IDLE.
- RUN, with full_adder driven by a=a_sh[0], b=b_sh[0], cin=carry. Each edge:
  - Shift the sum register right, inserting fa.sum at bit WIDTH-1.
  - carry <= fa.cout.
  - Shift a_sh and b_sh right by 1, zero-filled.
  - counter <= counter+1.
  - When counter == WIDTH-1 at the edge, go to DONE. After exactly WIDTH RUN edges the register holds the full sum, LSB aligned at bit 0.
- RUN input handling: in_valid and out_ready are ignored.
- DONE:
  - out_sum = sum register; out_cout = carry register.
  - Both are held stable while out_valid=1.
  - On out_valid && out_ready at an edge, go to IDLE.
  - out_sum and out_cout keep their last value after leaving DONE and are valid only while out_valid=1.
- Latency: accept edge at cycle k; out_valid is high after edge k+WIDTH. With out_ready tied high, the next accept is possible at edge k+WIDTH+2, giving a throughput of one add per WIDTH+2 cycles.
- Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, computed modulo 2^(WIDTH+1) with no truncation.
- Counter width: max(1, $clog2(WIDTH)). For WIDTH=1, RUN lasts exactly one cycle.
- Simultaneous events:
  - in_valid high in DONE: not accepted, because in_ready=0.
  - out_ready high in IDLE or RUN: no effect.
  - Accept and complete never coincide, because IDLE and DONE are distinct states.
- Only the full_adder instance performs arithmetic; no `+` operator is used in this block.

Test Plan:
- WIDTH=8, reset held 2 cycles then released -> in_ready=1, out_valid=0, busy=0, out_sum=0x00, out_cout=0.
- WIDTH=8, out_ready tied high; in_a=0xFF, in_b=0x01, in_cin=0 accepted at edge k -> out_valid high after edge k+8, out_sum=0x00, out_cout=1; in_ready high again after edge k+9.
- WIDTH=8, back-to-back additions, each checked against the reference model:
  - 0x7F+0x01, cin 0 -> 0x80, cout 0.
  - 0xA5+0x5A, cin 1 -> 0x00, cout 1.
  - 0x00+0x00, cin 0 -> 0x00, cout 0.
- WIDTH=8, backpressure:
  - Stimulus: 0x12+0x34, cin 0; hold out_ready low 5 cycles in DONE and pulse in_valid with new operands during that time.
  - Required: out_sum=0x46 and out_cout=0 stable throughout, in_ready=0, new operands not taken.
  - Release out_ready -> IDLE next edge.
- WIDTH=8, reset mid-op: accept 0xF0+0x0F, then drive rst_n low at the 3rd RUN edge -> after that edge state is IDLE, in_ready=1, busy=0, out_valid=0; a fresh 0x01+0x01 then yields 0x02, cout 0.
- WIDTH=1, all 8 combinations of (a, b, cin) -> {out_cout, out_sum} matches the full-adder truth table; out_valid high exactly 1 edge after accept.
